i2c_target_rx: RTL and testbench
================================

// Module: i2c_target_rx
// PURPOSE
// - Write-only I2C target (slave receiver); the far end of the I2C master byte transmitter on the same bus.
// - Oversamples SCL/SDA on clk, detects START/STOP, matches a 7-bit address, ACKs by pulling SDA low.
// - Delivers received bytes to the core through a valid/ready handshake. Used for board-level bring-up and loopback of the master.
// PARAMETERS
// - ADDR     7'h3C  7-bit target address; write transfers (R/W=0) to this address are ACKed.
// - SYNC_N   2      synchronizer depth on scl_in/sda_in; allowed range 2..3.
// PORTS
// - clk       in   1  system clock; must be >= 8x SCL frequency (3.58 MHz clk supports 400 kHz SCL).
// - rst_n     in   1  asynchronous, active-low reset.
// - scl_in    in   1  SCL pin level (asynchronous).
// - sda_in    in   1  SDA pin level (asynchronous).
// - sda_oe    out  1  1 = drive SDA low (open drain); 0 = release.
// - rx_data   out  8  last received data byte, MSB first on the wire.
// - rx_valid  out  1  one-clk pulse; rx_data holds a new byte.
// - rx_ready  in   1  core can accept a byte; sampled when a byte completes.
// - rx_start  out  1  one-clk pulse on an address match with W.
// - rx_stop   out  1  one-clk pulse on STOP/repeated START ending an addressed transfer.
// - busy      out  1  high from address match until STOP or repeated START.
// BEHAVIOUR
// - Reset: sda_oe=0, rx_data=0, rx_valid=rx_start=rx_stop=0, busy=0, state IDLE, bitcnt=0, sync flops=1.
// - Sync: SYNC_N flops per pin, then one delay flop; edges are taken from the synced level vs. the delayed level. Pin-to-event latency is SYNC_N+1 clk.
// - START = SDA fall while SCL high; STOP = SDA rise while SCL high. Both override every state.
// - Bits are sampled on SCL rise and shifted MSB first; bitcnt counts 0..8. sda_oe changes only on SCL fall, so SDA is never changed while SCL is high.
// - States and transitions:
//   IDLE:   START -> ADDR. All SCL activity is ignored.
//   ADDR:   8th SCL rise completes the byte {addr[6:0],rw}.
//           On the next SCL fall: if addr==ADDR && rw==0, set sda_oe=1, pulse rx_start, set busy, -> ACK.
//           Otherwise -> IGNORE with sda_oe=0 (read requests are NACKed).
//   ACK:    on SCL fall, release (sda_oe=0), clear bitcnt, -> DATA.
//   DATA:   8th SCL rise completes the byte. On the next SCL fall, rx_data is loaded and rx_valid pulses in that same clk.
//           If rx_ready=1, set sda_oe=1 and -> ACK.
//           If rx_ready=0, NACK (sda_oe=0), drop the byte with no rx_valid, -> IGNORE; busy stays 1.
//   IGNORE: wait for START/STOP; sda_oe=0.
// - STOP: -> IDLE, sda_oe=0, bitcnt=0. Pulse rx_stop and clear busy only if busy=1.
// - Repeated START: same as STOP for sda_oe, busy and rx_stop, then -> ADDR.
// - A START/STOP that arrives mid-byte discards the partial byte; rx_valid does not fire.
// - If START/STOP and an SCL edge are detected in the same clk, START/STOP wins.
// - Reset asserted mid-transfer releases SDA immediately (asynchronous).
// - A glitch shorter than 1 clk is not filtered beyond what the synchronizer does; no spike filter.
// STRUCTURE
// - Shared package i2c_pkg holds:
//   - state encoding (IDLE, ADDR, ACK, DATA, IGNORE; one-hot, 5 bits);
//   - SCL_FREQ=400000;
//   - the 7-bit address width constant shared with the master.
// - Sub-module i2c_pin_sync (SYNC_N flops + delay flop; outputs level, rise, fall), instantiated once for SCL and once for SDA.
// - Top level: FSM, 8-bit shift register, 4-bit bitcnt, output registers. All outputs are registered.
// TESTING
// - Write 0x78 (0x3C,W), then 0xA5, then STOP, with rx_ready=1. Expect: ACK on both bytes; rx_start 1 pulse; rx_valid 1 pulse with rx_data=0xA5; rx_stop 1 pulse; busy 1->0.
// - Write 0x7A (0x3D,W). Expect: NACK (SDA stays high in the 9th clock); no rx_start, no rx_valid; busy=0.
// - Write 0x79 (0x3C,R). Expect: NACK; state IGNORE until STOP.
// - 0x78, 0x11 (rx_ready=1), then 0x22 (rx_ready=0). Expect: 0x11 delivered and ACKed; 0x22 NACKed with no rx_valid; ACK of the next byte is suppressed until START.
// - 0x78, 4 bits of data, repeated START, 0x78, 0x5A, STOP. Expect: no rx_valid for the partial byte; rx_stop+rx_start at the restart; rx_data=0x5A.
// - Assert rst_n=0 while sda_oe=1 during ACK. Expect: sda_oe=0 the same clk; after release, the block ignores the bus until the next START.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared I2C definitions for the bus master and the target receiver.
// Contents:
//   ADDR_W    - 7-bit target address width, shared with the master
//   SCL_FREQ  - nominal SCL frequency (Hz)
//   ST_*      - one-hot FSM state encoding of the target receiver
//   is_write_to() - true when an address byte {addr,rw} is a write to addr
package i2c_pkg;

  localparam int ADDR_W   = 7;
  localparam int SCL_FREQ = 400000;
  localparam int STATE_W  = 5;

  localparam logic [STATE_W-1:0] ST_IDLE   = 5'b00001;
  localparam logic [STATE_W-1:0] ST_ADDR   = 5'b00010;
  localparam logic [STATE_W-1:0] ST_ACK    = 5'b00100;
  localparam logic [STATE_W-1:0] ST_DATA   = 5'b01000;
  localparam logic [STATE_W-1:0] ST_IGNORE = 5'b10000;

  function automatic logic is_write_to(input logic [7:0]        addr_byte,
                                       input logic [ADDR_W-1:0] addr);
    return (addr_byte[7:1] == addr) && (addr_byte[0] == 1'b0);
  endfunction

endpackage

// File: rtl/i2c_pin_sync.sv
// Pin synchronizer with edge detection for one asynchronous bus line.
// Ports:
//   clk     in  system clock
//   rst_n   in  asynchronous active-low reset (flops reset to 1, the idle bus level)
//   pin_i   in  asynchronous pin level
//   level_o out synchronized level
//   rise_o  out one-clk pulse when the synchronized level goes 0->1
//   fall_o  out one-clk pulse when the synchronized level goes 1->0
// SYNC_N is the synchronizer depth, 2 or 3.
module i2c_pin_sync #(
  parameter int SYNC_N = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_N-1:0] sync_q;
  logic              dly_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
      dly_q  <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_N-2:0], pin_i};
      dly_q  <= sync_q[SYNC_N-1];
    end
  end

  // Edges compare the synced level with its one-clk-delayed copy.
  assign level_o = sync_q[SYNC_N-1];
  assign rise_o  = level_o & ~dly_q;
  assign fall_o  = ~level_o & dly_q;

endmodule

// File: rtl/i2c_target_rx.sv
// Write-only I2C target receiver.
// Ports:
//   clk       in  system clock, >= 8x SCL
//   rst_n     in  asynchronous active-low reset
//   scl_in    in  SCL pin level (asynchronous)
//   sda_in    in  SDA pin level (asynchronous)
//   sda_oe    out 1 = pull SDA low (ACK), 0 = release
//   rx_data   out last delivered data byte
//   rx_valid  out one-clk pulse, rx_data holds a new byte
//   rx_ready  in  core can accept; sampled when a data byte completes
//   rx_start  out one-clk pulse on a write to ADDR
//   rx_stop   out one-clk pulse on STOP / repeated START ending an addressed transfer
//   busy      out high from address match until STOP or repeated START
module i2c_target_rx
  import i2c_pkg::*;
#(
  parameter logic [ADDR_W-1:0] ADDR   = 7'h3C,
  parameter int                SYNC_N = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_start,
  output logic       rx_stop,
  output logic       busy
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_pin_sync #(.SYNC_N(SYNC_N)) u_scl_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .pin_i   (scl_in),
    .level_o (scl_lvl),
    .rise_o  (scl_rise),
    .fall_o  (scl_fall)
  );

  i2c_pin_sync #(.SYNC_N(SYNC_N)) u_sda_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .pin_i   (sda_in),
    .level_o (sda_lvl),
    .rise_o  (sda_rise),
    .fall_o  (sda_fall)
  );

  logic start_cond, stop_cond;
  assign start_cond = sda_fall & scl_lvl;
  assign stop_cond  = sda_rise & scl_lvl;

  logic [STATE_W-1:0] state_q,    state_d;
  logic [7:0]         shift_q,    shift_d;
  logic [3:0]         bitcnt_q,   bitcnt_d;
  logic               sda_oe_q,   sda_oe_d;
  logic [7:0]         rx_data_q,  rx_data_d;
  logic               rx_valid_q, rx_valid_d;
  logic               rx_start_q, rx_start_d;
  logic               rx_stop_q,  rx_stop_d;
  logic               busy_q,     busy_d;

  logic byte_done;
  assign byte_done = (bitcnt_q == 4'd8);

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bitcnt_d   = bitcnt_q;
    sda_oe_d   = sda_oe_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    rx_start_d = 1'b0;
    rx_stop_d  = 1'b0;
    busy_d     = busy_q;

    if (start_cond || stop_cond) begin
      // Bus conditions override every state and discard any partial byte.
      sda_oe_d = 1'b0;
      bitcnt_d = 4'd0;
      state_d  = start_cond ? ST_ADDR : ST_IDLE;
      if (busy_q) begin
        rx_stop_d = 1'b1;
        busy_d    = 1'b0;
      end
    end else begin
      case (state_q)
        ST_ADDR, ST_DATA: begin
          // The SCL fall right after START arrives with bitcnt=0 and is ignored.
          if (scl_rise && !byte_done) begin
            shift_d  = {shift_q[6:0], sda_lvl};
            bitcnt_d = bitcnt_q + 4'd1;
          end else if (scl_fall && byte_done) begin
            bitcnt_d = 4'd0;
            if (state_q == ST_ADDR) begin
              if (is_write_to(shift_q, ADDR)) begin
                sda_oe_d   = 1'b1;
                rx_start_d = 1'b1;
                busy_d     = 1'b1;
                state_d    = ST_ACK;
              end else begin
                sda_oe_d = 1'b0;
                state_d  = ST_IGNORE;
              end
            end else if (rx_ready) begin
              rx_data_d  = shift_q;
              rx_valid_d = 1'b1;
              sda_oe_d   = 1'b1;
              state_d    = ST_ACK;
            end else begin
              // Core not ready: NACK and drop the byte; busy holds until STOP.
              sda_oe_d = 1'b0;
              state_d  = ST_IGNORE;
            end
          end
        end
        ST_ACK: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
            bitcnt_d = 4'd0;
            state_d  = ST_DATA;
          end
        end
        ST_IGNORE: begin
          sda_oe_d = 1'b0;
        end
        default: begin
          // IDLE (and any illegal encoding) waits for START with SDA released.
          sda_oe_d = 1'b0;
          state_d  = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      shift_q    <= 8'h00;
      bitcnt_q   <= 4'd0;
      sda_oe_q   <= 1'b0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      rx_start_q <= 1'b0;
      rx_stop_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bitcnt_q   <= bitcnt_d;
      sda_oe_q   <= sda_oe_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_start_q <= rx_start_d;
      rx_stop_q  <= rx_stop_d;
      busy_q     <= busy_d;
    end
  end

  assign sda_oe   = sda_oe_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign rx_start = rx_start_q;
  assign rx_stop  = rx_stop_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_target_rx.sv
// Testbench for i2c_target_rx: bit-banged I2C master, scoreboard of expected
// start/data/stop events, and a monitor that checks every DUT pulse.
module tb_i2c_target_rx;

  localparam logic [6:0] TADDR = 7'h3C;
  localparam int         Q     = 5;   // clks per quarter SCL period

  localparam int EV_START = 0;
  localparam int EV_DATA  = 1;
  localparam int EV_STOP  = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       scl_m, sda_m;
  logic       sda_bus;
  logic       rx_ready;
  logic       sda_oe, rx_valid, rx_start, rx_stop, busy;
  logic [7:0] rx_data;

  assign sda_bus = sda_m & ~sda_oe;

  i2c_target_rx #(.ADDR(TADDR), .SYNC_N(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .scl_in   (scl_m),
    .sda_in   (sda_bus),
    .sda_oe   (sda_oe),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .rx_start (rx_start),
    .rx_stop  (rx_stop),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         kind;
    logic [7:0] data;
  } ev_t;

  ev_t        exp_q[$];
  int         n_chk  = 0;
  int         n_pass = 0;
  logic [7:0] last_data;
  logic [7:0] d_arr[4];
  bit         r_arr[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
  endtask

  task automatic push_ev(input int kind, input logic [7:0] d);
    ev_t e;
    e.kind = kind;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic ev_got(input int kind, input logic [7:0] d);
    ev_t e;
    if (exp_q.size() == 0) begin
      check("unexpected_event", kind, 32'hFFFF);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", kind, e.kind);
      if (kind == EV_DATA) check("event_data", d, e.data);
    end
  endtask

  // Monitor: every output pulse is matched against the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_start) ev_got(EV_START, 8'h00);
      if (rx_valid) ev_got(EV_DATA, rx_data);
      if (rx_stop)  ev_got(EV_STOP, 8'h00);
    end
  end

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One SCL clock, entered and left with SCL low; returns SDA seen while SCL high.
  task automatic send_bit(input logic b, output logic sampled);
    sda_m = b;
    clks(Q);
    scl_m = 1'b1;
    clks(Q);
    sampled = sda_bus;
    clks(Q);
    scl_m = 1'b0;
    clks(Q);
  endtask

  task automatic gen_start();
    if (scl_m == 1'b0) begin
      sda_m = 1'b1;
      clks(Q);
      scl_m = 1'b1;
      clks(Q);
    end
    sda_m = 1'b0;
    clks(Q);
    scl_m = 1'b0;
    clks(Q);
  endtask

  task automatic gen_stop();
    sda_m = 1'b0;
    clks(Q);
    scl_m = 1'b1;
    clks(Q);
    sda_m = 1'b1;
    clks(2 * Q);
  endtask

  // Sends nbits MSB first; with nbits==8 also clocks the ACK bit and reports it.
  task automatic send_bits(input logic [7:0] b, input int nbits, output logic acked);
    logic s;
    for (int i = 0; i < nbits; i++) send_bit(b[7-i], s);
    acked = 1'b0;
    if (nbits == 8) begin
      send_bit(1'b1, s);
      acked = (s == 1'b0);
    end
  endtask

  // One transfer: START, address byte, nd data bytes (d_arr/r_arr), npart trailing
  // bits, then STOP or (restart=1) left open for the next START.
  task automatic run_xfer(input logic [7:0] abyte, input int nd, input int npart,
                          input bit restart);
    bit   addressed, accepting, exp_ack;
    logic acked;
    addressed = (abyte[7:1] == TADDR) && (abyte[0] == 1'b0);
    gen_start();
    if (addressed) push_ev(EV_START, 8'h00);
    send_bits(abyte, 8, acked);
    check("addr_ack", acked, addressed);
    check("busy_after_addr", busy, addressed);
    accepting = addressed;
    for (int i = 0; i < nd; i++) begin
      rx_ready = r_arr[i];
      exp_ack  = accepting && r_arr[i];
      if (exp_ack) begin
        push_ev(EV_DATA, d_arr[i]);
        last_data = d_arr[i];
      end
      send_bits(d_arr[i], 8, acked);
      check("data_ack", acked, exp_ack);
      if (!exp_ack) accepting = 1'b0;
    end
    if (npart > 0) send_bits(8'hC3, npart, acked);
    rx_ready = 1'b1;
    if (addressed) push_ev(EV_STOP, 8'h00);
    if (!restart) begin
      gen_stop();
      check("busy_after_stop", busy, 0);
      check("events_drained", exp_q.size(), 0);
    end
    check("rx_data_held", rx_data, last_data);
  endtask

  task automatic reset_mid_ack();
    logic [7:0] ab;
    logic       s, acked;
    ab = 8'h78;
    gen_start();
    push_ev(EV_START, 8'h00);
    for (int i = 0; i < 8; i++) send_bit(ab[7-i], s);
    clks(1);
    check("ack_driven", sda_oe, 1);
    rst_n = 1'b0;
    #1;
    check("rst_sda_oe", sda_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_rx_data", rx_data, 0);
    last_data = 8'h00;
    clks(2);
    rst_n = 1'b1;
    send_bit(1'b1, s);
    check("post_rst_no_ack", s, 1);
    send_bits(8'h5A, 8, acked);
    check("post_rst_data_nack", acked, 0);
    gen_stop();
    check("post_rst_busy", busy, 0);
    check("post_rst_events", exp_q.size(), 0);
  endtask

  initial begin
    scl_m     = 1'b1;
    sda_m     = 1'b1;
    rx_ready  = 1'b1;
    last_data = 8'h00;
    rst_n     = 1'b0;
    clks(3);
    check("reset_sda_oe", sda_oe, 0);
    check("reset_rx_data", rx_data, 0);
    check("reset_pulses", {rx_valid, rx_start, rx_stop}, 0);
    check("reset_busy", busy, 0);
    rst_n = 1'b1;
    clks(5);

    // Addressed write of one byte.
    d_arr[0] = 8'hA5; r_arr[0] = 1'b1;
    run_xfer(8'h78, 1, 0, 1'b0);
    // Wrong address.
    run_xfer(8'h7A, 0, 0, 1'b0);
    // Read request to own address, followed by a byte that must be ignored.
    d_arr[0] = 8'h33; r_arr[0] = 1'b1;
    run_xfer(8'h79, 1, 0, 1'b0);
    // Core stalls on the second byte; third byte stays un-ACKed.
    d_arr[0] = 8'h11; r_arr[0] = 1'b1;
    d_arr[1] = 8'h22; r_arr[1] = 1'b0;
    d_arr[2] = 8'h44; r_arr[2] = 1'b1;
    run_xfer(8'h78, 3, 0, 1'b0);
    // Partial byte cut by a repeated START.
    run_xfer(8'h78, 0, 4, 1'b1);
    d_arr[0] = 8'h5A; r_arr[0] = 1'b1;
    run_xfer(8'h78, 1, 0, 1'b0);
    // Reset while the target pulls SDA low.
    reset_mid_ack();
    clks(5);

    // Randomized transfers.
    for (int t = 0; t < 30; t++) begin
      logic [7:0] ab;
      int         sel, nd, npart;
      bit         rs;
      sel = $urandom_range(0, 5);
      if (sel <= 2)      ab = 8'h78;
      else if (sel == 3) ab = 8'h79;
      else if (sel == 4) ab = 8'h7A;
      else               ab = 8'($urandom_range(0, 255));
      nd    = $urandom_range(0, 3);
      npart = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
      rs    = (t != 29) && ($urandom_range(0, 2) == 0);
      for (int i = 0; i < nd; i++) begin
        d_arr[i] = 8'($urandom_range(0, 255));
        r_arr[i] = ($urandom_range(0, 4) != 0);
      end
      run_xfer(ab, nd, npart, rs);
    end

    clks(10);
    check("final_events_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
